mem_lsu: RTL and testbench

//   Load/store initiator between the core's execute stage and the word-addressed

---
 rtl/mem_lsu_if.sv | 30 +++
 rtl/mem_lsu.sv | 162 ++++++++++++++++
 tb/tb_mem_lsu.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Request/response and memory-side bus between the execute stage, the LSU and memory.
// slave is the LSU's view; master is the requester/memory side.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_rstrb, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_rstrb, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_lsu.sv
// Single-outstanding load/store unit: word-aligned reads, byte-masked writes,
// load alignment/extension and a one-cycle response pulse. All outputs registered.
module mem_lsu #(
  parameter int READ_LATENCY = 1
) (
  input  logic      clk,
  input  logic      resetn,
  mem_lsu_if.slave  bus
);
  localparam int CW = $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, RD, WT, WR, RSP} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_f3, w_f3;
  logic [1:0]    r_lane, w_lane;
  logic          r_ready, w_ready;
  logic          r_rvalid, w_rvalid;
  logic          r_err, w_err;
  logic          r_rstrb, w_rstrb;
  logic [31:0]   r_rdata, w_rdata;
  logic [31:0]   r_maddr, w_maddr;
  logic [31:0]   r_wdata, w_wdata;
  logic [3:0]    r_wmask, w_wmask;
  logic          w_illegal;
  logic [31:0]   w_shift;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  always_comb begin
    case (bus.req_funct3)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = bus.req_addr[0];
      3'b010:  w_illegal = |bus.req_addr[1:0];
      3'b100:  w_illegal = bus.req_we;
      3'b101:  w_illegal = bus.req_we | bus.req_addr[0];
      default: w_illegal = 1'b1;
    endcase
  end

  // Load lane select from the latched byte offset.
  always_comb begin
    w_shift = bus.mem_rdata >> {r_lane, 3'b000};
    w_byte  = w_shift[7:0];
    w_half  = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_f3     = r_f3;
    w_lane   = r_lane;
    w_rdata  = r_rdata;
    w_err    = r_err;
    w_maddr  = r_maddr;
    w_wdata  = r_wdata;
    w_rvalid = 1'b0;
    w_rstrb  = 1'b0;
    w_wmask  = 4'b0000;
    case (r_state)
      IDLE: if (bus.req_valid) begin
        w_f3    = bus.req_funct3;
        w_lane  = bus.req_addr[1:0];
        w_rdata = '0;
        w_err   = 1'b0;
        if (w_illegal) begin
          w_state  = RSP;
          w_err    = 1'b1;
          w_rvalid = 1'b1;
        end else begin
          w_maddr = {bus.req_addr[31:2], 2'b00};
          if (bus.req_we) begin
            w_state = WR;
            case (bus.req_funct3[1:0])
              2'b00: begin
                w_wdata = {4{bus.req_wdata[7:0]}};
                w_wmask = 4'b0001 << bus.req_addr[1:0];
              end
              2'b01: begin
                w_wdata = {2{bus.req_wdata[15:0]}};
                w_wmask = bus.req_addr[1] ? 4'b1100 : 4'b0011;
              end
              default: begin
                w_wdata = bus.req_wdata;
                w_wmask = 4'b1111;
              end
            endcase
          end else begin
            w_state = RD;
            w_rstrb = 1'b1;
          end
        end
      end
      RD: begin
        w_state = WT;
        w_cnt   = CW'(READ_LATENCY);
      end
      WT: begin
        w_cnt = r_cnt - CW'(1);
        // Data is valid in the last wait cycle, when the count drops to zero.
        if (r_cnt == CW'(1)) begin
          w_state  = RSP;
          w_rvalid = 1'b1;
          case (r_f3)
            3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
            3'b100:  w_rdata = {24'b0, w_byte};
            3'b101:  w_rdata = {16'b0, w_half};
            default: w_rdata = bus.mem_rdata;
          endcase
        end
      end
      WR: begin
        w_state  = RSP;
        w_rvalid = 1'b1;
      end
      RSP:     w_state = IDLE;
      default: w_state = IDLE;
    endcase
    w_ready = (w_state == IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_lane   <= '0;
      r_ready  <= 1'b1;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rstrb  <= 1'b0;
      r_rdata  <= '0;
      r_maddr  <= '0;
      r_wdata  <= '0;
      r_wmask  <= '0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_f3     <= w_f3;
      r_lane   <= w_lane;
      r_ready  <= w_ready;
      r_rvalid <= w_rvalid;
      r_err    <= w_err;
      r_rstrb  <= w_rstrb;
      r_rdata  <= w_rdata;
      r_maddr  <= w_maddr;
      r_wdata  <= w_wdata;
      r_wmask  <= w_wmask;
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_rvalid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.mem_addr   = r_maddr;
  assign bus.mem_rstrb  = r_rstrb;
  assign bus.mem_wdata  = r_wdata;
  assign bus.mem_wmask  = r_wmask;
endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: two instances (read latency 1 and 3), each with a
// small word memory model; directed requests push expectations checked by a monitor.
module tb_mem_lsu;
  logic clk;
  logic resetn;
  logic mem_init;

  mem_lsu_if ifa ();
  mem_lsu_if ifb ();

  mem_lsu #(.READ_LATENCY(1)) dut_a (.clk(clk), .resetn(resetn), .bus(ifa));
  mem_lsu #(.READ_LATENCY(3)) dut_b (.clk(clk), .resetn(resetn), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: rdata valid READ_LATENCY cycles after rstrb is sampled.
  logic [31:0] memA [16];
  logic [31:0] memB [16];
  logic [31:0] rdA;
  logic [31:0] pB [3];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) begin
        memA[i] <= (i == 4) ? 32'hDEADBEEF : 32'h0;
        memB[i] <= (i == 4) ? 32'hDEADBEEF : 32'h0;
      end
    end else begin
      for (int i = 0; i < 4; i++)
        if (ifa.mem_wmask[i]) memA[ifa.mem_addr[5:2]][8*i +: 8] <= ifa.mem_wdata[8*i +: 8];
      for (int i = 0; i < 4; i++)
        if (ifb.mem_wmask[i]) memB[ifb.mem_addr[5:2]][8*i +: 8] <= ifb.mem_wdata[8*i +: 8];
    end
    rdA   <= ifa.mem_rstrb ? memA[ifa.mem_addr[5:2]] : 32'hBADBAD00;
    pB[0] <= ifb.mem_rstrb ? memB[ifb.mem_addr[5:2]] : 32'hBADBAD00;
    pB[1] <= pB[0];
    pB[2] <= pB[1];
  end
  assign ifa.mem_rdata = rdA;
  assign ifb.mem_rdata = pB[2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor state per instance.
  int          lowc [2];
  int          nrd  [2];
  int          nwr  [2];
  logic [31:0] craddr [2];
  logic [31:0] cwaddr [2];
  logic [31:0] cwdata [2];
  logic [3:0]  cwmask [2];

  task automatic mon_step(input int d, input logic rv, input logic rdy, input logic rstrb,
                          input logic [3:0] wmask, input logic [31:0] maddr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    exp_t e;
    string p;
    p = $sformatf("d%0d_", d);
    if (!rdy) lowc[d]++; else lowc[d] = 0;
    if (rstrb) begin nrd[d]++; craddr[d] = maddr; end
    if (wmask != 4'b0) begin nwr[d]++; cwaddr[d] = maddr; cwdata[d] = wdata; cwmask[d] = wmask; end
    if (rv) begin
      if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
        chk({p, "unexpected_resp"}, 32'd1, 32'd0);
      end else begin
        e = (d == 1) ? qb.pop_front() : qa.pop_front();
        chk({p, "rdata"}, rdata, e.rdata);
        chk({p, "err"}, {31'b0, err}, {31'b0, e.err});
        chk({p, "latency"}, 32'(lowc[d]), 32'(e.lat));
        chk({p, "rstrb_pulses"}, 32'(nrd[d]), 32'(e.nrd));
        chk({p, "wmask_pulses"}, 32'(nwr[d]), 32'(e.nwr));
        if (e.nrd != 0) begin
          chk({p, "rd_addr"}, craddr[d], e.maddr);
          chk({p, "rsp_addr_hold"}, maddr, e.maddr);
        end
        if (e.nwr != 0) begin
          chk({p, "wr_addr"}, cwaddr[d], e.maddr);
          chk({p, "wr_data"}, cwdata[d], e.wdata);
          chk({p, "wr_mask"}, {28'b0, cwmask[d]}, {28'b0, e.wmask});
          chk({p, "rsp_addr_hold"}, maddr, e.maddr);
        end
      end
      nrd[d] = 0;
      nwr[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      for (int d = 0; d < 2; d++) begin
        lowc[d] = 0; nrd[d] = 0; nwr[d] = 0;
      end
    end else begin
      mon_step(0, ifa.resp_valid, ifa.req_ready, ifa.mem_rstrb, ifa.mem_wmask,
               ifa.mem_addr, ifa.mem_wdata, ifa.resp_rdata, ifa.resp_err);
      mon_step(1, ifb.resp_valid, ifb.req_ready, ifb.mem_rstrb, ifb.mem_wmask,
               ifb.mem_addr, ifb.mem_wdata, ifb.resp_rdata, ifb.resp_err);
    end
  end

  function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                              input int nr, input int nw, input logic [31:0] maddr,
                              input logic [31:0] wdata, input logic [3:0] wmask);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.nrd = nr; e.nwr = nw;
    e.maddr = maddr; e.wdata = wdata; e.wmask = wmask;
    return e;
  endfunction

  task automatic issue(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input exp_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!((d == 1) ? ifb.req_ready : ifa.req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    if (d == 1) begin
      qb.push_back(e);
      ifb.req_valid = 1'b1; ifb.req_we = we; ifb.req_funct3 = f3;
      ifb.req_addr = a; ifb.req_wdata = wd;
    end else begin
      qa.push_back(e);
      ifa.req_valid = 1'b1; ifa.req_we = we; ifa.req_funct3 = f3;
      ifa.req_addr = a; ifa.req_wdata = wd;
    end
    @(negedge clk);
    ifa.req_valid = 1'b0;
    ifb.req_valid = 1'b0;
  endtask

  task automatic ld(input int d, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    issue(d, 1'b0, f3, a, 32'h0, mk(r, 1'b0, (d == 1) ? 5 : 3, 1, 0, a & ~32'h3, 32'h0, 4'h0));
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] ewd, input logic [3:0] m);
    issue(0, 1'b1, f3, a, wd, mk(32'h0, 1'b0, 2, 0, 1, a & ~32'h3, ewd, m));
  endtask

  task automatic er(input logic we, input logic [2:0] f3, input logic [31:0] a);
    issue(0, we, f3, a, 32'h55AA55AA, mk(32'h0, 1'b1, 1, 0, 0, 32'h0, 32'h0, 4'h0));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, {31'b0, ifa.req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'b0, ifa.resp_valid}, 32'd0);
    chk({tag, "_resp_rdata"}, ifa.resp_rdata, 32'd0);
    chk({tag, "_resp_err"}, {31'b0, ifa.resp_err}, 32'd0);
    chk({tag, "_mem_addr"}, ifa.mem_addr, 32'd0);
    chk({tag, "_mem_rstrb"}, {31'b0, ifa.mem_rstrb}, 32'd0);
    chk({tag, "_mem_wdata"}, ifa.mem_wdata, 32'd0);
    chk({tag, "_mem_wmask"}, {28'b0, ifa.mem_wmask}, 32'd0);
  endtask

  initial begin
    int n;
    ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_funct3 = 3'b0;
    ifa.req_addr = 32'h0; ifa.req_wdata = 32'h0;
    ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_funct3 = 3'b0;
    ifb.req_addr = 32'h0; ifb.req_wdata = 32'h0;
    resetn = 1'b0;
    mem_init = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_b_ready", {31'b0, ifb.req_ready}, 32'd1);
    mem_init = 1'b0;
    resetn = 1'b1;

    // Loads of MEM[4]=DEADBEEF
    ld(0, 3'b010, 32'h10, 32'hDEADBEEF);
    ld(0, 3'b000, 32'h13, 32'hFFFFFFDE);
    ld(0, 3'b100, 32'h13, 32'h000000DE);
    ld(0, 3'b001, 32'h12, 32'hFFFFDEAD);
    ld(0, 3'b101, 32'h10, 32'h0000BEEF);

    // Stores, with read-back through the memory model
    st(3'b000, 32'h11, 32'h123456AB, 32'hABABABAB, 4'b0010);
    ld(0, 3'b010, 32'h10, 32'hDEADABEF);
    st(3'b010, 32'h20, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111);
    st(3'b001, 32'h22, 32'h00007654, 32'h76547654, 4'b1100);
    ld(0, 3'b010, 32'h20, 32'h7654F00D);
    ld(0, 3'b000, 32'h21, 32'hFFFFFFF0);
    ld(0, 3'b101, 32'h22, 32'h00007654);
    ld(0, 3'b001, 32'h20, 32'hFFFFF00D);

    // Illegal requests
    er(1'b1, 3'b001, 32'h13);
    er(1'b0, 3'b011, 32'h10);
    er(1'b0, 3'b010, 32'h12);
    er(1'b1, 3'b100, 32'h10);
    er(1'b0, 3'b110, 32'h10);
    er(1'b0, 3'b001, 32'h11);
    ld(0, 3'b000, 32'h10, 32'hFFFFFFEF);

    // Longer read latency
    ld(1, 3'b010, 32'h10, 32'hDEADBEEF);
    ld(1, 3'b100, 32'h12, 32'h000000AD);

    // Reset while waiting for read data: no response, all outputs cleared
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin @(negedge clk); n++; end
    ld(0, 3'b010, 32'h10, 32'hDEADABEF);
    @(negedge clk);
    qa.delete(qa.size() - 1);
    resetn = 1'b0;
    #1;
    chk_idle("midreset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    ld(0, 3'b010, 32'h10, 32'hDEADABEF);

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin @(negedge clk); n++; end
    if (qa.size() != 0 || qb.size() != 0) chk("drain_timeout", 32'(qa.size() + qb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
